// File: rtl/ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ctrl_pkg
// Shared encodings for the instruction-sequencing control FSM:
//   state_e   - 3-bit FSM state codes (also driven out on ctrl_fsm.state)
//   inst_e    - 4-bit decoded instruction classes presented on inst_type
//   cause_e   - 3-bit trap cause codes presented on trap_cause
//   is_load() - true for any of the three load widths
// ----------------------------------------------------------------------------
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_LOAD   = 3'd1,
        ST_STORE  = 3'd2,
        ST_MULDIV = 3'd3,
        ST_EXEC   = 3'd4,
        ST_TRAP   = 3'd5,
        ST_HALT   = 3'd6
    } state_e;

    // Codes not listed here are ordinary ALU-class instructions.
    typedef enum logic [3:0] {
        INST_ALU       = 4'd0,
        INST_LOAD_BYTE = 4'd1,
        INST_LOAD_HALF = 4'd2,
        INST_LOAD_WORD = 4'd3,
        INST_STORE     = 4'd4,
        INST_MULDIV    = 4'd5,
        INST_ILLEGAL   = 4'd15
    } inst_e;

    typedef enum logic [2:0] {
        CAUSE_NONE      = 3'd0,
        CAUSE_FETCH_ERR = 3'd1,
        CAUSE_LOAD_ERR  = 3'd2,
        CAUSE_STORE_ERR = 3'd3,
        CAUSE_ILLEGAL   = 3'd4,
        CAUSE_TIMEOUT   = 3'd5
    } cause_e;

    function automatic logic is_load(input logic [3:0] inst);
        return (inst == INST_LOAD_BYTE) || (inst == INST_LOAD_HALF) ||
               (inst == INST_LOAD_WORD);
    endfunction

endpackage

// File: rtl/ctrl_timer.sv
// ----------------------------------------------------------------------------
// ctrl_timer
// Wait-cycle counter used by ctrl_fsm to bound how long it sits in a bus or
// MULDIV wait. The count advances on every enabled cycle and stops at the
// limit; a limit of zero never expires.
// Ports:
//   clock   in  1  sole clock
//   reset   in  1  async active-high reset, clears the count
//   clear   in  1  synchronous clear (takes priority over enable)
//   enable  in  1  count this cycle
//   limit   in  W  expiry threshold, 0 disables
//   expired out 1  count has reached limit while enabled
// ----------------------------------------------------------------------------
module ctrl_timer #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] limit,
    output logic         expired
);

    logic [W-1:0] count;

    assign expired = enable && (limit != '0) && (count == limit);

    // NOTE: registered state is always assigned with <= so every flop samples
    // the pre-edge values of its inputs regardless of block ordering.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/ctrl_fsm.sv
// ----------------------------------------------------------------------------
// ctrl_fsm
// Instruction-sequencing control FSM: fetches over the IFU, dispatches to
// LOAD/STORE (LSU), MULDIV or single-cycle EXEC, raises one-cycle traps on
// bus errors, illegal instructions and wait timeouts, and counts retired
// instructions. Bus states run a request phase (reqValid held until reqReady)
// followed by a response phase (waiting for respValid).
// Ports:
//   clock, reset          sole clock, async active-high reset
//   inst_type   in  4     decoded instruction class, valid with ifu_respValid
//   halt_req    in  1     stop at the next instruction boundary
//   ifu_reqReady/ifu_respValid/ifu_respErr  in  1  instruction fetch bus
//   lsu_reqReady/lsu_respValid/lsu_respErr  in  1  load/store bus
//   muldiv_done in  1     multiply/divide unit finished
//   ifu_reqValid, lsu_reqValid, muldiv_start, pc_wen, reg_wen,
//   finished, trap        out 1  combinational control strobes
//   trap_cause  out 3     cause of the most recent trap
//   state       out 3     current FSM state
//   instret     out INSTRET_W  retired-instruction count (wraps)
// ----------------------------------------------------------------------------
module ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int INSTRET_W      = 32,
    parameter int HAS_MULDIV     = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [3:0]           inst_type,
    input  logic                 halt_req,
    input  logic                 ifu_reqReady,
    input  logic                 ifu_respValid,
    input  logic                 ifu_respErr,
    input  logic                 lsu_reqReady,
    input  logic                 lsu_respValid,
    input  logic                 lsu_respErr,
    input  logic                 muldiv_done,
    output logic                 ifu_reqValid,
    output logic                 lsu_reqValid,
    output logic                 muldiv_start,
    output logic                 pc_wen,
    output logic                 reg_wen,
    output logic                 finished,
    output logic                 trap,
    output logic [2:0]           trap_cause,
    output logic [2:0]           state,
    output logic [INSTRET_W-1:0] instret
);

    localparam int              TMR_W     = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT_CYCLES);

    logic [2:0]           state_q, state_d;
    logic                 req_phase_q, req_phase_d;  // 1: request phase, 0: response phase
    logic [2:0]           cause_q, cause_d;
    logic [INSTRET_W-1:0] instret_q;
    logic                 retire;
    logic                 tmr_clear, tmr_enable, tmr_expired;

    assign tmr_enable = (state_q == ST_FETCH) || (state_q == ST_LOAD) ||
                        (state_q == ST_STORE) || (state_q == ST_MULDIV);
    assign tmr_clear  = (state_d != state_q);

    ctrl_timer #(.W(TMR_W)) u_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (tmr_clear),
        .enable  (tmr_enable),
        .limit   (TMR_LIMIT),
        .expired (tmr_expired)
    );

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        req_phase_d  = req_phase_q;
        cause_d      = cause_q;
        retire       = 1'b0;
        ifu_reqValid = 1'b0;
        lsu_reqValid = 1'b0;
        muldiv_start = 1'b0;
        pc_wen       = 1'b0;
        reg_wen      = 1'b0;
        finished     = 1'b0;
        trap         = 1'b0;

        case (state_q)
            ST_FETCH: begin
                if (req_phase_q) begin
                    // On expiry the request is withdrawn so no handshake can
                    // complete on the way into TRAP.
                    if (tmr_expired) begin
                        state_d = ST_TRAP;
                        cause_d = CAUSE_TIMEOUT;
                    end else begin
                        ifu_reqValid = 1'b1;
                        if (ifu_reqReady) req_phase_d = 1'b0;
                    end
                end else if (ifu_respValid) begin
                    // A response always beats a simultaneous timeout.
                    if (ifu_respErr) begin
                        state_d = ST_TRAP;
                        cause_d = CAUSE_FETCH_ERR;
                    end else begin
                        pc_wen = 1'b1;
                        if (is_load(inst_type)) begin
                            state_d = ST_LOAD;
                        end else if (inst_type == INST_STORE) begin
                            state_d = ST_STORE;
                        end else if (inst_type == INST_MULDIV && HAS_MULDIV != 0) begin
                            state_d      = ST_MULDIV;
                            muldiv_start = 1'b1;
                        end else if (inst_type == INST_MULDIV || inst_type == INST_ILLEGAL) begin
                            state_d = ST_TRAP;
                            cause_d = CAUSE_ILLEGAL;
                        end else begin
                            state_d = ST_EXEC;
                            reg_wen = 1'b1;
                        end
                    end
                end else if (tmr_expired) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end

            ST_LOAD, ST_STORE: begin
                if (req_phase_q) begin
                    if (tmr_expired) begin
                        state_d = ST_TRAP;
                        cause_d = CAUSE_TIMEOUT;
                    end else begin
                        lsu_reqValid = 1'b1;
                        if (lsu_reqReady) req_phase_d = 1'b0;
                    end
                end else if (lsu_respValid) begin
                    if (lsu_respErr) begin
                        state_d = ST_TRAP;
                        cause_d = (state_q == ST_LOAD) ? CAUSE_LOAD_ERR : CAUSE_STORE_ERR;
                    end else if (state_q == ST_LOAD) begin
                        state_d = ST_EXEC;
                        reg_wen = 1'b1;
                    end else begin
                        // A store retires directly; there is no write-back.
                        finished = 1'b1;
                        retire   = 1'b1;
                        state_d  = halt_req ? ST_HALT : ST_FETCH;
                    end
                end else if (tmr_expired) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end

            ST_MULDIV: begin
                if (muldiv_done) begin
                    state_d = ST_EXEC;
                    reg_wen = 1'b1;
                end else if (tmr_expired) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end

            ST_EXEC: begin
                finished = 1'b1;
                retire   = 1'b1;
                state_d  = halt_req ? ST_HALT : ST_FETCH;
            end

            ST_TRAP: begin
                trap    = 1'b1;
                state_d = halt_req ? ST_HALT : ST_FETCH;
            end

            ST_HALT: begin
                if (!halt_req) state_d = ST_FETCH;
            end

            default: state_d = ST_FETCH;
        endcase

        // Every bus state is entered in its request phase.
        if (state_d != state_q) req_phase_d = 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_FETCH;
            req_phase_q <= 1'b1;
            cause_q     <= CAUSE_NONE;
            instret_q   <= '0;
        end else begin
            state_q     <= state_d;
            req_phase_q <= req_phase_d;
            cause_q     <= cause_d;
            if (retire) instret_q <= instret_q + INSTRET_W'(1);
        end
    end

    assign state      = state_q;
    assign trap_cause = cause_q;
    assign instret    = instret_q;

endmodule

// File: tb/tb_ctrl_fsm.sv
// ----------------------------------------------------------------------------
// tb_ctrl_fsm
// Three ctrl_fsm instances share one set of inputs:
//   dut    - default parameters (main vector table, MULDIV, halt, reset)
//   dut_to - TIMEOUT_CYCLES=4 (timeout corners)
//   dut_nm - HAS_MULDIV=0 (MULDIV decodes as illegal)
// Inputs change on the falling edge; outputs are compared 1 time unit later,
// i.e. the values the FSM acts on at the next rising edge.
// Packed strobe order: {ifu_reqValid, lsu_reqValid, muldiv_start, pc_wen,
//                       reg_wen, finished, trap}
// Packed input order:  {halt_req, ifu_reqReady, ifu_respValid, ifu_respErr,
//                       lsu_reqReady, lsu_respValid, lsu_respErr, muldiv_done}
// ----------------------------------------------------------------------------
module tb_ctrl_fsm;
    import ctrl_pkg::*;

    logic       clock;
    logic       reset;
    logic [3:0] inst_type;
    logic       halt_req;
    logic       ifu_reqReady, ifu_respValid, ifu_respErr;
    logic       lsu_reqReady, lsu_respValid, lsu_respErr;
    logic       muldiv_done;

    logic        a_ifu_rv, a_lsu_rv, a_ms, a_pcw, a_rgw, a_fin, a_trp;
    logic [2:0]  a_cause, a_state;
    logic [31:0] a_instret;
    logic        b_ifu_rv, b_lsu_rv, b_ms, b_pcw, b_rgw, b_fin, b_trp;
    logic [2:0]  b_cause, b_state;
    logic [31:0] b_instret;
    logic        c_ifu_rv, c_lsu_rv, c_ms, c_pcw, c_rgw, c_fin, c_trp;
    logic [2:0]  c_cause, c_state;
    logic [31:0] c_instret;

    logic [6:0] a_out, b_out, c_out;
    assign a_out = {a_ifu_rv, a_lsu_rv, a_ms, a_pcw, a_rgw, a_fin, a_trp};
    assign b_out = {b_ifu_rv, b_lsu_rv, b_ms, b_pcw, b_rgw, b_fin, b_trp};
    assign c_out = {c_ifu_rv, c_lsu_rv, c_ms, c_pcw, c_rgw, c_fin, c_trp};

    ctrl_fsm dut (
        .clock(clock), .reset(reset), .inst_type(inst_type), .halt_req(halt_req),
        .ifu_reqReady(ifu_reqReady), .ifu_respValid(ifu_respValid), .ifu_respErr(ifu_respErr),
        .lsu_reqReady(lsu_reqReady), .lsu_respValid(lsu_respValid), .lsu_respErr(lsu_respErr),
        .muldiv_done(muldiv_done),
        .ifu_reqValid(a_ifu_rv), .lsu_reqValid(a_lsu_rv), .muldiv_start(a_ms),
        .pc_wen(a_pcw), .reg_wen(a_rgw), .finished(a_fin), .trap(a_trp),
        .trap_cause(a_cause), .state(a_state), .instret(a_instret)
    );

    ctrl_fsm #(.TIMEOUT_CYCLES(4)) dut_to (
        .clock(clock), .reset(reset), .inst_type(inst_type), .halt_req(halt_req),
        .ifu_reqReady(ifu_reqReady), .ifu_respValid(ifu_respValid), .ifu_respErr(ifu_respErr),
        .lsu_reqReady(lsu_reqReady), .lsu_respValid(lsu_respValid), .lsu_respErr(lsu_respErr),
        .muldiv_done(muldiv_done),
        .ifu_reqValid(b_ifu_rv), .lsu_reqValid(b_lsu_rv), .muldiv_start(b_ms),
        .pc_wen(b_pcw), .reg_wen(b_rgw), .finished(b_fin), .trap(b_trp),
        .trap_cause(b_cause), .state(b_state), .instret(b_instret)
    );

    ctrl_fsm #(.HAS_MULDIV(0)) dut_nm (
        .clock(clock), .reset(reset), .inst_type(inst_type), .halt_req(halt_req),
        .ifu_reqReady(ifu_reqReady), .ifu_respValid(ifu_respValid), .ifu_respErr(ifu_respErr),
        .lsu_reqReady(lsu_reqReady), .lsu_respValid(lsu_respValid), .lsu_respErr(lsu_respErr),
        .muldiv_done(muldiv_done),
        .ifu_reqValid(c_ifu_rv), .lsu_reqValid(c_lsu_rv), .muldiv_start(c_ms),
        .pc_wen(c_pcw), .reg_wen(c_rgw), .finished(c_fin), .trap(c_trp),
        .trap_cause(c_cause), .state(c_state), .instret(c_instret)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs at the falling edge (also releases reset).
    task automatic cyc(input logic [3:0] inst, input logic [7:0] b);
        @(negedge clock);
        reset     = 1'b0;
        inst_type = inst;
        {halt_req, ifu_reqReady, ifu_respValid, ifu_respErr,
         lsu_reqReady, lsu_respValid, lsu_respErr, muldiv_done} = b;
        #1;
    endtask

    // Leaves reset asserted across one rising edge; the next cyc() releases it.
    task automatic do_reset();
        @(negedge clock);
        reset     = 1'b1;
        inst_type = 4'd0;
        {halt_req, ifu_reqReady, ifu_respValid, ifu_respErr,
         lsu_reqReady, lsu_respValid, lsu_respErr, muldiv_done} = 8'd0;
        @(posedge clock);
    endtask

    typedef struct {
        logic [3:0]  inst;
        logic [7:0]  in_bits;
        logic [6:0]  exp_out;
        logic [2:0]  exp_state;
        logic [2:0]  exp_cause;
        logic [31:0] exp_instret;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [3:0] inst, input logic [7:0] ib,
                                input logic [6:0] eo, input logic [2:0] st,
                                input logic [2:0] ca, input logic [31:0] ir);
        vec_t v;
        v.inst = inst; v.in_bits = ib; v.exp_out = eo;
        v.exp_state = st; v.exp_cause = ca; v.exp_instret = ir;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ms_a, ms_c;
        reset = 1'b1;
        inst_type = 4'd0;
        {halt_req, ifu_reqReady, ifu_respValid, ifu_respErr,
         lsu_reqReady, lsu_respValid, lsu_respErr, muldiv_done} = 8'd0;

        // ---------------- reset state ----------------
        #2;
        check("reset_out",     32'(a_out),   32'(7'b1000000));
        check("reset_state",   32'(a_state), 32'(ST_FETCH));
        check("reset_cause",   32'(a_cause), 32'(CAUSE_NONE));
        check("reset_instret", a_instret,    32'd0);
        @(posedge clock);

        // ---------------- main vector table (default parameters) ----------------
        // ALU: reqReady after 3 wait cycles, response 2 cycles after handshake
        vecs.push_back(mk(INST_ALU,       8'b0000_0000, 7'b1000000, ST_FETCH, CAUSE_NONE, 0));
        vecs.push_back(mk(INST_ALU,       8'b0000_0000, 7'b1000000, ST_FETCH, CAUSE_NONE, 0));
        vecs.push_back(mk(INST_ALU,       8'b0000_0000, 7'b1000000, ST_FETCH, CAUSE_NONE, 0));
        vecs.push_back(mk(INST_ALU,       8'b0100_0000, 7'b1000000, ST_FETCH, CAUSE_NONE, 0));
        vecs.push_back(mk(INST_ALU,       8'b0000_0000, 7'b0000000, ST_FETCH, CAUSE_NONE, 0));
        vecs.push_back(mk(INST_ALU,       8'b0010_0000, 7'b0001100, ST_FETCH, CAUSE_NONE, 0));
        vecs.push_back(mk(INST_ALU,       8'b0000_0000, 7'b0000010, ST_EXEC,  CAUSE_NONE, 0));
        // LOAD_WORD: stale IFU response in request phase ignored; LSU response on 5th LOAD cycle
        vecs.push_back(mk(INST_LOAD_WORD, 8'b0010_0000, 7'b1000000, ST_FETCH, CAUSE_NONE, 1));
        vecs.push_back(mk(INST_LOAD_WORD, 8'b0100_0000, 7'b1000000, ST_FETCH, CAUSE_NONE, 1));
        vecs.push_back(mk(INST_LOAD_WORD, 8'b0010_0000, 7'b0001000, ST_FETCH, CAUSE_NONE, 1));
        vecs.push_back(mk(INST_ALU,       8'b0000_0100, 7'b0100000, ST_LOAD,  CAUSE_NONE, 1));
        vecs.push_back(mk(INST_ALU,       8'b0000_1000, 7'b0100000, ST_LOAD,  CAUSE_NONE, 1));
        vecs.push_back(mk(INST_ALU,       8'b0000_0000, 7'b0000000, ST_LOAD,  CAUSE_NONE, 1));
        vecs.push_back(mk(INST_ALU,       8'b0000_0000, 7'b0000000, ST_LOAD,  CAUSE_NONE, 1));
        vecs.push_back(mk(INST_ALU,       8'b0000_0100, 7'b0000100, ST_LOAD,  CAUSE_NONE, 1));
        vecs.push_back(mk(INST_ALU,       8'b0000_0000, 7'b0000010, ST_EXEC,  CAUSE_NONE, 1));
        // STORE with error: one TRAP cycle, instret unchanged, cause held afterwards
        vecs.push_back(mk(INST_STORE,     8'b0100_0000, 7'b1000000, ST_FETCH, CAUSE_NONE, 2));
        vecs.push_back(mk(INST_STORE,     8'b0010_0000, 7'b0001000, ST_FETCH, CAUSE_NONE, 2));
        vecs.push_back(mk(INST_ALU,       8'b0000_1000, 7'b0100000, ST_STORE, CAUSE_NONE, 2));
        vecs.push_back(mk(INST_ALU,       8'b0000_0110, 7'b0000000, ST_STORE, CAUSE_NONE, 2));
        vecs.push_back(mk(INST_ALU,       8'b0000_0000, 7'b0000001, ST_TRAP,  CAUSE_STORE_ERR, 2));
        // Good STORE: finished on the response, straight back to FETCH
        vecs.push_back(mk(INST_ALU,       8'b0100_0000, 7'b1000000, ST_FETCH, CAUSE_STORE_ERR, 2));
        vecs.push_back(mk(INST_STORE,     8'b0010_0000, 7'b0001000, ST_FETCH, CAUSE_STORE_ERR, 2));
        vecs.push_back(mk(INST_ALU,       8'b0000_1000, 7'b0100000, ST_STORE, CAUSE_STORE_ERR, 2));
        vecs.push_back(mk(INST_ALU,       8'b0000_0100, 7'b0000010, ST_STORE, CAUSE_STORE_ERR, 2));
        // Fetch error: no pc_wen
        vecs.push_back(mk(INST_ALU,       8'b0100_0000, 7'b1000000, ST_FETCH, CAUSE_STORE_ERR, 3));
        vecs.push_back(mk(INST_ALU,       8'b0011_0000, 7'b0000000, ST_FETCH, CAUSE_STORE_ERR, 3));
        vecs.push_back(mk(INST_ALU,       8'b0000_0000, 7'b0000001, ST_TRAP,  CAUSE_FETCH_ERR, 3));
        // Illegal instruction: pc_wen, then trap
        vecs.push_back(mk(INST_ALU,       8'b0100_0000, 7'b1000000, ST_FETCH, CAUSE_FETCH_ERR, 3));
        vecs.push_back(mk(INST_ILLEGAL,   8'b0010_0000, 7'b0001000, ST_FETCH, CAUSE_FETCH_ERR, 3));
        vecs.push_back(mk(INST_ALU,       8'b0000_0000, 7'b0000001, ST_TRAP,  CAUSE_ILLEGAL, 3));
        // LOAD_BYTE with error
        vecs.push_back(mk(INST_ALU,       8'b0100_0000, 7'b1000000, ST_FETCH, CAUSE_ILLEGAL, 3));
        vecs.push_back(mk(INST_LOAD_BYTE, 8'b0010_0000, 7'b0001000, ST_FETCH, CAUSE_ILLEGAL, 3));
        vecs.push_back(mk(INST_ALU,       8'b0000_1000, 7'b0100000, ST_LOAD,  CAUSE_ILLEGAL, 3));
        vecs.push_back(mk(INST_ALU,       8'b0000_0110, 7'b0000000, ST_LOAD,  CAUSE_ILLEGAL, 3));
        vecs.push_back(mk(INST_ALU,       8'b0000_0000, 7'b0000001, ST_TRAP,  CAUSE_LOAD_ERR, 3));
        // Unlisted code 7 behaves as ALU
        vecs.push_back(mk(INST_ALU,       8'b0100_0000, 7'b1000000, ST_FETCH, CAUSE_LOAD_ERR, 3));
        vecs.push_back(mk(4'd7,           8'b0010_0000, 7'b0001100, ST_FETCH, CAUSE_LOAD_ERR, 3));
        vecs.push_back(mk(INST_ALU,       8'b0000_0000, 7'b0000010, ST_EXEC,  CAUSE_LOAD_ERR, 3));
        vecs.push_back(mk(INST_ALU,       8'b0000_0000, 7'b1000000, ST_FETCH, CAUSE_LOAD_ERR, 4));

        foreach (vecs[i]) begin
            cyc(vecs[i].inst, vecs[i].in_bits);
            check($sformatf("vec%0d_out", i),     32'(a_out),   32'(vecs[i].exp_out));
            check($sformatf("vec%0d_state", i),   32'(a_state), 32'(vecs[i].exp_state));
            check($sformatf("vec%0d_cause", i),   32'(a_cause), 32'(vecs[i].exp_cause));
            check($sformatf("vec%0d_instret", i), a_instret,    vecs[i].exp_instret);
        end

        // ---------------- timeout with ifu_reqReady stuck low (limit 4) ----------------
        // Count is 0..3 in FETCH cycles 1-4; it hits 4 in cycle 5, where the
        // request is dropped and TRAP is entered at the following edge.
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            cyc(INST_ALU, 8'b0000_0000);
            check($sformatf("to_wait%0d_out", k), 32'(b_out), 32'(7'b1000000));
        end
        cyc(INST_ALU, 8'b0000_0000);
        check("to_expire_out",   32'(b_out),   32'(7'b0000000));
        check("to_expire_state", 32'(b_state), 32'(ST_FETCH));
        cyc(INST_ALU, 8'b0000_0000);
        check("to_trap_out",   32'(b_out),   32'(7'b0000001));
        check("to_trap_state", 32'(b_state), 32'(ST_TRAP));
        check("to_trap_cause", 32'(b_cause), 32'(CAUSE_TIMEOUT));
        check("to_trap_instret", b_instret, 32'd0);

        // Response lands in the same cycle the count reaches the limit: completes normally
        cyc(INST_ALU, 8'b0100_0000);
        check("to_race_req_out",   32'(b_out),   32'(7'b1000000));
        check("to_race_req_state", 32'(b_state), 32'(ST_FETCH));
        for (int k = 0; k < 3; k++) cyc(INST_ALU, 8'b0000_0000);
        cyc(INST_ALU, 8'b0010_0000);
        check("to_race_resp_out", 32'(b_out), 32'(7'b0001100));
        cyc(INST_ALU, 8'b0000_0000);
        check("to_race_exec_state", 32'(b_state), 32'(ST_EXEC));
        check("to_race_exec_out",   32'(b_out),   32'(7'b0000010));

        // ---------------- MULDIV (dut) vs no-MULDIV (dut_nm) ----------------
        do_reset();
        ms_a = 0;
        ms_c = 0;
        cyc(INST_ALU, 8'b0100_0000);
        cyc(INST_MULDIV, 8'b0010_0000);
        ms_a += int'(a_ms);
        ms_c += int'(c_ms);
        check("md_issue_out",    32'(a_out), 32'(7'b0011000));
        check("md_nm_issue_out", 32'(c_out), 32'(7'b0001000));
        for (int k = 1; k <= 9; k++) begin
            cyc(INST_ALU, 8'b0000_0000);
            ms_a += int'(a_ms);
            ms_c += int'(c_ms);
            if (k == 1) begin
                check("md_nm_trap_state", 32'(c_state), 32'(ST_TRAP));
                check("md_nm_trap_cause", 32'(c_cause), 32'(CAUSE_ILLEGAL));
                check("md_nm_trap_out",   32'(c_out),   32'(7'b0000001));
            end
        end
        check("md_wait_state", 32'(a_state), 32'(ST_MULDIV));
        cyc(INST_ALU, 8'b0000_0001);
        ms_a += int'(a_ms);
        ms_c += int'(c_ms);
        check("md_done_out",   32'(a_out),   32'(7'b0000100));
        check("md_done_state", 32'(a_state), 32'(ST_MULDIV));
        cyc(INST_ALU, 8'b0000_0000);
        check("md_exec_out",   32'(a_out),   32'(7'b0000010));
        check("md_exec_state", 32'(a_state), 32'(ST_EXEC));
        cyc(INST_ALU, 8'b0000_0000);
        check("md_instret",     a_instret, 32'd1);
        check("md_start_count", 32'(ms_a), 32'd1);
        check("md_nm_start_count", 32'(ms_c), 32'd0);
        check("md_nm_instret",  c_instret, 32'd0);

        // ---------------- halt_req during LOAD ----------------
        do_reset();
        cyc(INST_ALU, 8'b0100_0000);
        cyc(INST_LOAD_HALF, 8'b0010_0000);
        cyc(INST_ALU, 8'b1000_1000);
        check("halt_ld_req_out", 32'(a_out), 32'(7'b0100000));
        cyc(INST_ALU, 8'b1000_0100);
        check("halt_ld_resp_out",   32'(a_out),   32'(7'b0000100));
        check("halt_ld_resp_state", 32'(a_state), 32'(ST_LOAD));
        cyc(INST_ALU, 8'b1000_0000);
        check("halt_exec_out",   32'(a_out),   32'(7'b0000010));
        check("halt_exec_state", 32'(a_state), 32'(ST_EXEC));
        for (int k = 0; k < 3; k++) begin
            cyc(INST_ALU, 8'b1100_0000);
            check($sformatf("halt_hold%0d_state", k), 32'(a_state), 32'(ST_HALT));
            check($sformatf("halt_hold%0d_out", k),   32'(a_out),   32'(7'b0000000));
        end
        cyc(INST_ALU, 8'b0000_0000);
        check("halt_release_state", 32'(a_state), 32'(ST_HALT));
        cyc(INST_ALU, 8'b0000_0000);
        check("halt_refetch_state", 32'(a_state), 32'(ST_FETCH));
        check("halt_refetch_out",   32'(a_out),   32'(7'b1000000));
        check("halt_instret",       a_instret,    32'd1);

        // ---------------- halt_req at a TRAP boundary ----------------
        cyc(INST_ALU, 8'b0100_0000);
        cyc(INST_ALU, 8'b0011_0000);
        cyc(INST_ALU, 8'b1000_0000);
        check("halt_trap_state", 32'(a_state), 32'(ST_TRAP));
        cyc(INST_ALU, 8'b0000_0000);
        check("halt_after_trap_state", 32'(a_state), 32'(ST_HALT));

        // ---------------- reset mid-LOAD ----------------
        do_reset();
        cyc(INST_ALU, 8'b0100_0000);
        cyc(INST_ALU, 8'b0010_0000);
        cyc(INST_ALU, 8'b0000_0000);
        cyc(INST_ALU, 8'b0100_0000);
        cyc(INST_LOAD_WORD, 8'b0010_0000);
        cyc(INST_ALU, 8'b0000_1000);
        cyc(INST_ALU, 8'b0000_0000);
        check("rst_ld_pre_state",   32'(a_state), 32'(ST_LOAD));
        check("rst_ld_pre_instret", a_instret,    32'd1);
        #2 reset = 1'b1;
        #1;
        check("rst_ld_async_state",   32'(a_state), 32'(ST_FETCH));
        check("rst_ld_async_instret", a_instret,    32'd0);
        check("rst_ld_async_out",     32'(a_out),   32'(7'b1000000));
        @(posedge clock);
        // Stale responses right after release must be ignored in the request phase
        cyc(INST_ALU, 8'b0010_0100);
        check("rst_ld_stale_out",   32'(a_out),   32'(7'b1000000));
        cyc(INST_ALU, 8'b0000_0000);
        check("rst_ld_stale_state", 32'(a_state), 32'(ST_FETCH));
        check("rst_ld_stale_cause", 32'(a_cause), 32'(CAUSE_NONE));
        check("rst_ld_stale_instret", a_instret,  32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ctrl_fsm.md
CTRL_FSM -- requirements
Module: ctrl_fsm

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: wait-cycle limit before a timeout trap; 0 disables the timeout.
REQ-002 SHALL have parameter INSTRET_W, default 32: width of the retired-instruction counter.
REQ-003 SHALL have parameter HAS_MULDIV, default 1: 1 enables the MULDIV state; 0 makes INST_MULDIV illegal.
REQ-004 SHALL have one clock and an asynchronous, active-high reset; ports clock then reset: clock  in  1  sole clock; reset  in  1  async active-high reset.
REQ-005 SHALL have inputs inst_type in 4 (decoded instruction class, valid with ifu_respValid) and halt_req in 1 (stop at the next instruction boundary).
REQ-006 SHALL have IFU inputs ifu_reqReady, ifu_respValid and ifu_respErr, each in 1.
REQ-007 SHALL have LSU inputs lsu_reqReady, lsu_respValid and lsu_respErr, each in 1, plus muldiv_done in 1.
REQ-008 SHALL have 1-bit outputs ifu_reqValid, lsu_reqValid, muldiv_start, pc_wen, reg_wen, finished and trap.
REQ-009 SHALL have outputs trap_cause out 3, state out 3 (current state) and instret out INSTRET_W.

Function
REQ-010 SHALL use states FETCH, LOAD, STORE, MULDIV, EXEC, TRAP and HALT, encoded in 3 bits; ifu_reqValid, lsu_reqValid, pc_wen, reg_wen, finished, muldiv_start and trap SHALL be combinational from state, the pending flag and inputs.
REQ-011 SHALL have each bus state enter a request phase: reqValid high, held until reqReady is sampled high; the following cycle starts the response phase.
REQ-012 SHALL ignore respValid while in the request phase; the earliest response is the cycle after the handshake.
REQ-013 FETCH, on ifu_respValid with ifu_respErr=0, SHALL pulse pc_wen and branch on inst_type: LOAD_BYTE/HALF/WORD -> LOAD; STORE -> STORE; MULDIV -> MULDIV with a muldiv_start pulse; ILLEGAL -> TRAP with cause ILLEGAL; otherwise -> EXEC with a reg_wen pulse.
REQ-014 FETCH, on ifu_respValid with ifu_respErr=1, SHALL not pulse pc_wen and SHALL go -> TRAP with cause FETCH_ERR.
REQ-015 With HAS_MULDIV=0, INST_MULDIV SHALL go -> TRAP with cause ILLEGAL and no muldiv_start.
REQ-016 LOAD, on lsu_respValid, SHALL go -> EXEC with a reg_wen pulse when err=0, or -> TRAP with cause LOAD_ERR when err=1.
REQ-017 STORE, on lsu_respValid with err=0, SHALL pulse finished, increment instret and go -> FETCH (or HALT if halt_req); with err=1 it SHALL go -> TRAP with cause STORE_ERR.
REQ-018 MULDIV, on muldiv_done, SHALL pulse reg_wen and go -> EXEC.
REQ-019 EXEC SHALL last one cycle: finished=1, instret+1, then -> HALT if halt_req else -> FETCH.
REQ-020 TRAP SHALL last one cycle: trap=1, trap_cause registered on entry and held until the next trap, no instret increment, then -> FETCH (or HALT if halt_req).
REQ-021 HALT SHALL drive all request outputs low and go -> FETCH the first cycle halt_req is sampled low.
REQ-022 The timeout counter SHALL count every cycle spent in a request or response phase of FETCH/LOAD/STORE or in MULDIV, and SHALL clear on every state change.
REQ-023 When the timeout count reaches TIMEOUT_CYCLES, the block SHALL go -> TRAP with cause TIMEOUT and drop reqValid.
REQ-024 If a response (or muldiv_done) and the timeout occur in the same cycle, the response SHALL win.
REQ-025 instret SHALL wrap modulo 2^INSTRET_W.
REQ-026 halt_req SHALL be sampled only at the EXEC, STORE-completion and TRAP boundaries; in-flight transactions SHALL complete first.

Reset
REQ-027 SHALL, on reset assertion, immediately set state=FETCH in request phase, clear the timeout count, set instret=0 and trap_cause=NONE.
REQ-028 SHALL assert ifu_reqValid=1 during and right after reset, with all other 1-bit outputs 0.
REQ-029 Reset mid-transaction SHALL abandon it, and any response arriving after reset release while in the request phase SHALL be ignored per REQ-012.

Structure
REQ-030 Package ctrl_pkg SHALL hold the state enum, the INST_* codes (LOAD_BYTE, LOAD_HALF, LOAD_WORD, STORE, MULDIV, ILLEGAL, ALU) and the trap-cause codes NONE, FETCH_ERR, LOAD_ERR, STORE_ERR, ILLEGAL, TIMEOUT.
REQ-031 The timeout counter SHALL be sub-module ctrl_timer (clear, enable, limit, expired); the FSM and instret SHALL stay in ctrl_fsm.

Verification
REQ-032 ALU instruction with ifu_reqReady delayed 3 cycles and response 2 cycles later -> reqValid high 4 cycles; pc_wen and reg_wen pulse together; finished next cycle; instret 0->1.
REQ-033 LOAD_WORD with LSU response after 5 cycles -> lsu_reqValid held until ready; reg_wen on the response cycle; EXEC; finished.
REQ-034 STORE with lsu_respErr=1 -> TRAP one cycle, trap_cause=STORE_ERR, instret unchanged, then FETCH.
REQ-035 TIMEOUT_CYCLES=4 with ifu_reqReady stuck low -> trap on the 5th FETCH cycle with cause TIMEOUT; response and timeout in the same cycle -> normal completion.
REQ-036 MULDIV with HAS_MULDIV=1 and done after 10 cycles -> muldiv_start once, reg_wen, finished; HAS_MULDIV=0 -> trap ILLEGAL.
REQ-037 halt_req during LOAD -> LOAD completes, EXEC, HALT held while high, FETCH on release; reset mid-LOAD -> FETCH with instret=0.
